pemstat_madd: RTL and testbench
===============================

PEMSTAT_MADD -- requirements
Module: pemstat_madd

Interface
REQ-001 SHALL have parameter NCH, default 4: number of statistics channels (1..16).
REQ-002 SHALL have parameter ACC_W, default 24: accumulator width per channel (16..31).
REQ-003 SHALL have parameter ADD_W, default 16: addend width (ADD_W <= ACC_W).
REQ-004 SHALL have parameter CH_W, default 2: channel index width, at least clog2(NCH).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port inc_en  input  1  accumulate strobe.
REQ-008 SHALL have port inc_ch  input  CH_W  channel to accumulate.
REQ-009 SHALL have port inc_val  input  ADD_W  addend, unsigned.
REQ-010 SHALL have port ld_en  input  1  host load strobe.
REQ-011 SHALL have port ld_ch  input  CH_W  channel to load.
REQ-012 SHALL have port ld_data  input  31  load value; bits [ACC_W-1:0] used.
REQ-013 SHALL have port rd_en  input  1  host read strobe.
REQ-014 SHALL have port rd_ch  input  CH_W  channel to read.
REQ-015 SHALL have port rd_clr  input  1  clear-on-read qualifier for rd_en.
REQ-016 SHALL have port carry_clr  input  1  clear all carry flags.
REQ-017 SHALL have port rd_data  output  31  read value, zero-extended from ACC_W.
REQ-018 SHALL have port rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-019 SHALL have port carry  output  NCH  per-channel overflow flag.

Function
REQ-020 SHALL compute sum = acc[inc_ch] + zero-extended inc_val at ACC_W+1 bits; bit ACC_W is the carry-out.
REQ-021 SHALL resolve each channel's update with priority: ld hit -> ld_data; inc hit with rd_en&rd_clr hit -> inc_val; inc hit -> sum[ACC_W-1:0]; rd_en&rd_clr hit -> 0; else hold.
REQ-022 SHALL update independent channels in the same cycle when strobes target different channels.
REQ-023 SHALL register rd_data one cycle after rd_en from the pre-update accumulator value, and pulse rd_valid for exactly that cycle.
REQ-024 SHALL hold rd_data at its last value while rd_valid is 0.
REQ-025 SHALL set carry[ch] on an inc hit to ch with carry-out 1, and SHALL NOT set it when ld also hits ch.
REQ-026 SHALL clear all carry bits on carry_clr, which has priority over a same-cycle set.
REQ-027 SHALL leave carry unchanged on load or clear-on-read.
REQ-028 SHALL ignore any strobe whose channel index is >= NCH (no state change; rd_valid pulses with rd_data 0).
REQ-029 SHALL wrap modulo 2^ACC_W on overflow when saturation is compiled out.

Reset
REQ-030 SHALL on rst_n low immediately clear all accumulators, carry, rd_data and rd_valid to 0, aborting any in-flight read.
REQ-031 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-032 SHALL, with PEMSTAT_MADD_SAT_EN defined, load all-ones into the accumulator on overflow instead of wrapping, still setting carry.
REQ-033 SHALL, without PEMSTAT_MADD_SAT_EN, wrap per REQ-029 and contain no saturation logic.

Verification (NCH=4, ACC_W=24, ADD_W=16)
REQ-034 SHALL cover: reset, then inc ch2 with 0x1234 twice, then rd ch2 -> rd_valid and rd_data 0x002468 next cycle; carry 0.
REQ-035 SHALL cover: ld ch1 0xFFFFF0, then inc ch1 with 0x0020 -> acc 0x000010 and carry[1]=1 (SAT_EN: 0xFFFFFF); then carry_clr -> carry 0.
REQ-036 SHALL cover: acc0=0x000100, rd ch0 with rd_clr plus inc ch0 with 0x0005 in the same cycle -> rd_data 0x000100, acc0 0x000005.
REQ-037 SHALL cover: ld ch3 0x000050 plus inc ch3 with 0x0010 in the same cycle -> acc3 0x000050; overflowing inc plus carry_clr in the same cycle -> carry 0.
REQ-038 SHALL cover: rst_n low mid-read between clk edges -> rd_valid, rd_data, carry and all accumulators 0 without a clock edge.

Source files
------------

// File: rtl/pemstat_madd.sv
// ============================================================================
//  Module   : pemstat_madd
//  Purpose  : Multi-channel statistics accumulator. Each channel holds an
//             ACC_W-bit unsigned count that can be incremented by an addend,
//             loaded by the host, or read (optionally clearing it). A sticky
//             per-channel carry flag records overflow.
//  Ports    : clk, rst_n (async, active-low)
//             inc_en/inc_ch/inc_val      - accumulate strobe, channel, addend
//             ld_en/ld_ch/ld_data        - host load strobe, channel, value
//             rd_en/rd_ch/rd_clr         - host read strobe, channel, clear
//             carry_clr                  - clear all carry flags
//             rd_data/rd_valid           - registered read result + pulse
//             carry                      - per-channel overflow flags
//  Config   : define PEMSTAT_MADD_SAT_EN to saturate to all-ones on overflow
//             instead of wrapping modulo 2^ACC_W.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pemstat_madd #(
    parameter int NCH   = 4,
    parameter int ACC_W = 24,
    parameter int ADD_W = 16,
    parameter int CH_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_en,
    input  logic [CH_W-1:0]   inc_ch,
    input  logic [ADD_W-1:0]  inc_val,
    input  logic              ld_en,
    input  logic [CH_W-1:0]   ld_ch,
    input  logic [30:0]       ld_data,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic              rd_clr,
    input  logic              carry_clr,
    output logic [30:0]       rd_data,
    output logic              rd_valid,
    output logic [NCH-1:0]    carry
);

    logic [ACC_W-1:0] w_acc [NCH];
    logic [NCH-1:0]   w_carry;
    logic [ACC_W-1:0] w_inc_acc;
    logic [ACC_W-1:0] w_rd_acc;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_inc_res;
    logic [30:0]      r_rd_data;
    logic             r_rd_valid;

    // Channel selection by explicit compare: an index >= NCH matches no
    // channel, so the selected value stays 0 and no channel is touched.
    always_comb begin
        w_inc_acc = '0;
        w_rd_acc  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (inc_ch == CH_W'(i)) w_inc_acc = w_acc[i];
            if (rd_ch  == CH_W'(i)) w_rd_acc  = w_acc[i];
        end
    end

    // One shared adder; bit ACC_W is the carry-out.
    assign w_sum = {1'b0, w_inc_acc} + (ACC_W+1)'(inc_val);

    always_comb begin
`ifdef PEMSTAT_MADD_SAT_EN
        w_inc_res = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
        w_inc_res = w_sum[ACC_W-1:0];
`endif
    end

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            logic             w_ld_hit;
            logic             w_inc_hit;
            logic             w_clr_hit;
            logic [ACC_W-1:0] r_acc;
            logic             r_carry;

            assign w_ld_hit  = ld_en  && (ld_ch  == CH_W'(g));
            assign w_inc_hit = inc_en && (inc_ch == CH_W'(g));
            assign w_clr_hit = rd_en  && rd_clr && (rd_ch == CH_W'(g));

            // Load beats everything; an increment racing a clear-on-read
            // starts the channel afresh from the addend so no event is lost.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_acc <= '0;
                end else if (w_ld_hit) begin
                    r_acc <= ld_data[ACC_W-1:0];
                end else if (w_inc_hit && w_clr_hit) begin
                    r_acc <= ACC_W'(inc_val);
                end else if (w_inc_hit) begin
                    r_acc <= w_inc_res;
                end else if (w_clr_hit) begin
                    r_acc <= '0;
                end
            end

            // Sticky overflow flag; a global clear wins over a same-cycle set.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_carry <= 1'b0;
                end else if (carry_clr) begin
                    r_carry <= 1'b0;
                end else if (w_inc_hit && !w_ld_hit && w_sum[ACC_W]) begin
                    r_carry <= 1'b1;
                end
            end

            assign w_acc[g]   = r_acc;
            assign w_carry[g] = r_carry;
        end

        if (ACC_W < 31) begin : g_ld_unused
            logic w_unused_ld;
            assign w_unused_ld = ^ld_data[30:ACC_W];
        end
    endgenerate

    // Read returns the value before this cycle's update; rd_data holds
    // between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= 31'(w_rd_acc);
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign carry    = w_carry;

endmodule

`default_nettype wire

// File: tb/tb_pemstat_madd.sv
// ============================================================================
//  Module   : tb_pemstat_madd
//  Purpose  : Self-checking bench for pemstat_madd (NCH=4, ACC_W=24,
//             ADD_W=16, CH_W=3 so out-of-range channels can be driven).
//             Directed scenarios followed by randomized traffic; read
//             results are checked by a scoreboard monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pemstat_madd;

    localparam int     NCH   = 4;
    localparam int     ACC_W = 24;
    localparam int     ADD_W = 16;
    localparam int     CH_W  = 3;
    localparam longint MOD   = 64'd1 << ACC_W;
`ifdef PEMSTAT_MADD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             inc_en;
    logic [CH_W-1:0]  inc_ch;
    logic [ADD_W-1:0] inc_val;
    logic             ld_en;
    logic [CH_W-1:0]  ld_ch;
    logic [30:0]      ld_data;
    logic             rd_en;
    logic [CH_W-1:0]  rd_ch;
    logic             rd_clr;
    logic             carry_clr;
    logic [30:0]      rd_data;
    logic             rd_valid;
    logic [NCH-1:0]   carry;

    pemstat_madd #(.NCH(NCH), .ACC_W(ACC_W), .ADD_W(ADD_W), .CH_W(CH_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .inc_en(inc_en), .inc_ch(inc_ch), .inc_val(inc_val),
        .ld_en(ld_en), .ld_ch(ld_ch), .ld_data(ld_data),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_clr(rd_clr),
        .carry_clr(carry_clr),
        .rd_data(rd_data), .rd_valid(rd_valid), .carry(carry)
    );

    always #5 clk = ~clk;

    // Reference state: plain integers per channel.
    longint         m_acc [NCH];
    logic [NCH-1:0] m_carry;
    longint         sb[$];
    longint         last_rd;
    int             n_cmp = 0;
    int             n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per rd_valid cycle; otherwise rd_data
    // must hold the last read value.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            last_rd = 0;
        end else if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rd_valid_unexpected", 1, 0);
            end else begin
                longint e;
                e = sb.pop_front();
                chk("rd_data", longint'(rd_data), e);
                last_rd = e;
            end
        end else begin
            chk("rd_data_hold", longint'(rd_data), last_rd);
        end
    end

    task automatic idle_inputs();
        inc_en = 0; inc_ch = '0; inc_val = '0;
        ld_en = 0;  ld_ch = '0;  ld_data = '0;
        rd_en = 0;  rd_ch = '0;  rd_clr = 0;
        carry_clr = 0;
    endtask

    // One clock of stimulus; the model applies the same strobes by rule.
    task automatic do_cyc(input logic ie, input int ich, input int unsigned ival,
                          input logic le, input int lch, input int unsigned ldat,
                          input logic re, input int rch, input logic rc,
                          input logic cc);
        longint         nxt [NCH];
        logic [NCH-1:0] nc;
        longint         v, d, s;
        logic           ih, lh, ch_h, ovf;
        v = longint'(ival) % (64'd1 << ADD_W);
        d = (longint'(ldat) & 64'h7FFF_FFFF) % MOD;
        inc_en = ie; inc_ch = CH_W'(ich); inc_val = ADD_W'(ival);
        ld_en = le;  ld_ch = CH_W'(lch);  ld_data = 31'(ldat);
        rd_en = re;  rd_ch = CH_W'(rch);  rd_clr = rc;
        carry_clr = cc;
        if (re) sb.push_back((rch < NCH) ? m_acc[rch] : 0);
        nc = m_carry;
        for (int c = 0; c < NCH; c++) begin
            ih   = ie && (ich == c);
            lh   = le && (lch == c);
            ch_h = re && rc && (rch == c);
            s    = m_acc[c] + v;
            ovf  = (s >= MOD);
            nxt[c] = m_acc[c];
            if (lh)              nxt[c] = d;
            else if (ih && ch_h) nxt[c] = v;
            else if (ih)         nxt[c] = ovf ? (SAT ? MOD - 1 : s - MOD) : s;
            else if (ch_h)       nxt[c] = 0;
            if (ih && !lh && ovf) nc[c] = 1'b1;
        end
        if (cc) nc = '0;
        @(posedge clk);
        for (int c = 0; c < NCH; c++) m_acc[c] = nxt[c];
        m_carry = nc;
        #1;
        idle_inputs();
        chk("carry", longint'(carry), longint'(m_carry));
    endtask

    task automatic inc(input int ch, input int unsigned v);
        do_cyc(1, ch, v, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic ld(input int ch, input int unsigned d);
        do_cyc(0, 0, 0, 1, ch, d, 0, 0, 0, 0);
    endtask
    task automatic rd(input int ch, input logic clr);
        do_cyc(0, 0, 0, 0, 0, 0, 1, ch, clr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        for (int c = 0; c < NCH; c++) m_acc[c] = 0;
        m_carry = '0;
        last_rd = 0;
        rst_n   = 1'b0;
        #3;
        chk("reset_rd_valid", longint'(rd_valid), 0);
        chk("reset_rd_data",  longint'(rd_data), 0);
        chk("reset_carry",    longint'(carry), 0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Two increments then a read.
        inc(2, 32'h1234);
        inc(2, 32'h1234);
        rd(2, 0);

        // Wrap/saturate with carry, then clear carry.
        ld(1, 32'hFFFFF0);
        inc(1, 32'h0020);
        rd(1, 0);
        do_cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Clear-on-read racing an increment.
        ld(0, 32'h100);
        do_cyc(1, 0, 5, 0, 0, 0, 1, 0, 1, 0);
        rd(0, 0);

        // Load beats increment; carry_clr beats an overflow set.
        do_cyc(1, 3, 32'h10, 1, 3, 32'h50, 0, 0, 0, 0);
        rd(3, 0);
        ld(2, 32'hFFFFFF);
        do_cyc(1, 2, 1, 0, 0, 0, 0, 0, 0, 1);

        // Out-of-range channels: no effect, read returns 0.
        do_cyc(1, 5, 7, 1, 6, 32'h123, 1, 4, 1, 0);
        for (int c = 0; c < NCH; c++) rd(c, 0);

        // Asynchronous reset in the middle of a read.
        ld(3, 32'hFFFFFF);
        inc(3, 1);
        rd(1, 0);
        #1 rst_n = 1'b0;
        sb.delete();
        for (int c = 0; c < NCH; c++) m_acc[c] = 0;
        m_carry = '0;
        #1;
        chk("async_rst_rd_valid", longint'(rd_valid), 0);
        chk("async_rst_rd_data",  longint'(rd_data), 0);
        chk("async_rst_carry",    longint'(carry), 0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < NCH; c++) rd(c, 0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            int unsigned ldv;
            ldv = ($urandom_range(0, 1) == 1) ? (32'hFFFF00 + $urandom_range(0, 255)) : $urandom;
            do_cyc(logic'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom,
                   logic'($urandom_range(0, 3) == 0), $urandom_range(0, 5), ldv,
                   logic'($urandom_range(0, 1)), $urandom_range(0, 5),
                   logic'($urandom_range(0, 2) == 0),
                   logic'($urandom_range(0, 9) == 0));
        end
        for (int c = 0; c < NCH; c++) rd(c, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drain", longint'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
